// File: rtl/knight_rd_pkg.sv
// ============================================================================
// knight_rd_pkg: shared state, mode and decode definitions for the LED scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package knight_rd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN_UP   = 2'd1,
        SCAN_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_e;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_TRAIL  = 2'b01;
    localparam logic [1:0] MODE_WRAP   = 2'b10;

    // 32-bit wide so any legal LED count can slice what it needs
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/knight_rd_prescaler.sv
// ============================================================================
// knight_rd_prescaler: loadable down-counter with enable and zero flag
// Rev 1.0
// ============================================================================
`default_nettype none

module knight_rd_prescaler #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/knight_rd_scanner.sv
// ============================================================================
// knight_rd_scanner: knight-rider LED scan engine (bounce, trail, wrap)
// Rev 1.0
// ============================================================================
`default_nettype none

module knight_rd_scanner
    import knight_rd_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int POS_W    = $clog2(NUM_LEDS)
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_enable,
    input  logic [1:0]          cfg_mode,
    input  logic [31:0]         cfg_period,
    input  logic [POS_W-1:0]    cfg_start_pos,
    input  logic                cfg_load,
    output logic [NUM_LEDS-1:0] leds,
    output logic [POS_W-1:0]    pos,
    output logic                dir,
    output logic                step_pulse,
    output logic                sweep_done,
    output logic                running
);

    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] ONE  = POS_W'(1);

    state_e                state_q;
    logic [1:0]            mode_q;
    logic [31:0]           period_q;
    logic [POS_W-1:0]      start_q;
    logic [POS_W-1:0]      pos_q;
    logic                  dir_q;
    logic                  step_q;
    logic                  sweep_q;
    logic [NUM_LEDS-1:0]   leds_q;

    logic [1:0]            mode_d;
    logic [31:0]           period_d;
    logic [POS_W-1:0]      start_d;
    logic [POS_W-1:0]      next_pos_d;
    logic                  next_dir_d;
    logic                  sweep_d;
    logic [NUM_LEDS-1:0]   leds_d;
    logic [NUM_LEDS-1:0]   idle_leds;
    logic                  scanning;
    logic                  presc_zero;
    logic                  step;

    assign mode_d   = (cfg_mode == 2'b11) ? MODE_BOUNCE : cfg_mode;
    assign period_d = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
    assign start_d  = ({{(32-POS_W){1'b0}}, cfg_start_pos} > 32'(NUM_LEDS - 1)) ? LAST : cfg_start_pos;

    assign scanning = (state_q == SCAN_UP) || (state_q == SCAN_DOWN);
    assign step     = scanning && presc_zero;

    knight_rd_prescaler #(
        .WIDTH (32)
    ) u_prescaler (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .load_i     (((state_q == IDLE) && cfg_enable) || step),
        .load_val_i (period_q - 32'd1),
        .en_i       (scanning && cfg_enable),
        .zero_o     (presc_zero)
    );

    // Wrap mode overrides a downward sweep: next step moves up again
    always_comb begin
        next_pos_d = pos_q;
        next_dir_d = dir_q;
        sweep_d    = 1'b0;
        if (mode_q == MODE_WRAP) begin
            next_dir_d = 1'b1;
            if (pos_q == LAST) begin
                next_pos_d = '0;
                sweep_d    = 1'b1;
            end else begin
                next_pos_d = pos_q + ONE;
            end
        end else if (state_q == SCAN_DOWN) begin
            if (pos_q == '0) begin
                next_pos_d = ONE;
                next_dir_d = 1'b1;
                sweep_d    = 1'b1;
            end else begin
                next_pos_d = pos_q - ONE;
            end
        end else begin
            if (pos_q == LAST) begin
                next_pos_d = LAST - ONE;
                next_dir_d = 1'b0;
                sweep_d    = 1'b1;
            end else begin
                next_pos_d = pos_q + ONE;
            end
        end
        leds_d = NUM_LEDS'(onehot(5'(next_pos_d)))
               | ((mode_q == MODE_TRAIL) ? NUM_LEDS'(onehot(5'(pos_q))) : '0);
    end

    assign idle_leds = NUM_LEDS'(onehot(5'(start_q)));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            mode_q   <= MODE_BOUNCE;
            period_q <= 32'd1;
            start_q  <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            step_q   <= 1'b0;
            sweep_q  <= 1'b0;
            leds_q   <= '0;
        end else begin
            step_q  <= 1'b0;
            sweep_q <= 1'b0;
            if (cfg_load) begin
                mode_q   <= mode_d;
                period_q <= period_d;
                start_q  <= start_d;
            end
            case (state_q)
                IDLE: begin
                    pos_q <= start_q;
                    if (cfg_enable) begin
                        state_q <= SCAN_UP;
                        dir_q   <= 1'b1;
                        leds_q  <= idle_leds;
                    end
                end
                SCAN_UP, SCAN_DOWN: begin
                    if (step) begin
                        pos_q   <= next_pos_d;
                        dir_q   <= next_dir_d;
                        leds_q  <= leds_d;
                        step_q  <= 1'b1;
                        sweep_q <= sweep_d;
                    end
                    if (!cfg_enable) begin
                        state_q <= HOLD;
                    end else if (step) begin
                        state_q <= next_dir_d ? SCAN_UP : SCAN_DOWN;
                    end
                end
                HOLD: begin
                    if (cfg_enable) begin
                        state_q <= dir_q ? SCAN_UP : SCAN_DOWN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign leds       = leds_q;
    assign pos        = pos_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign sweep_done = sweep_q;
    assign running    = scanning;

endmodule

`default_nettype wire

// File: tb/tb_knight_rd_scanner.sv
// ============================================================================
// tb_knight_rd_scanner: randomized scoreboard bench for knight_rd_scanner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_knight_rd_scanner;

    localparam int N = 8;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cfg_enable;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_period;
    logic [2:0]  cfg_start_pos;
    logic        cfg_load;
    logic [7:0]  leds;
    logic [2:0]  pos;
    logic        dir, step_pulse, sweep_done, running;

    logic [2:0]  d6_start;
    logic        d6_load;
    logic [5:0]  d6_leds;
    logic [2:0]  d6_pos;
    logic        d6_dir, d6_step, d6_sweep, d6_run;

    always #5 ACLK = ~ACLK;

    knight_rd_scanner #(.NUM_LEDS(N)) u_dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .cfg_enable    (cfg_enable),
        .cfg_mode      (cfg_mode),
        .cfg_period    (cfg_period),
        .cfg_start_pos (cfg_start_pos),
        .cfg_load      (cfg_load),
        .leds          (leds),
        .pos           (pos),
        .dir           (dir),
        .step_pulse    (step_pulse),
        .sweep_done    (sweep_done),
        .running       (running)
    );

    knight_rd_scanner #(.NUM_LEDS(6)) u_dut6 (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .cfg_enable    (1'b0),
        .cfg_mode      (2'b00),
        .cfg_period    (32'd1),
        .cfg_start_pos (d6_start),
        .cfg_load      (d6_load),
        .leds          (d6_leds),
        .pos           (d6_pos),
        .dir           (d6_dir),
        .step_pulse    (d6_step),
        .sweep_done    (d6_sweep),
        .running       (d6_run)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: position moves by +/-1 with reflection at the ends,
    // one step every 'period' enabled cycles.
    typedef struct {
        int         cyc;
        int         pos;
        logic [7:0] leds;
        bit         sw;
    } exp_t;

    exp_t       q[$];
    bit         m_active = 0, m_run = 0;
    int         m_pos = 0, m_dir = 1, m_rem = 0, m_period = 1, m_mode = 0, m_start = 0;
    logic [7:0] m_leds = '0;
    int         np;
    bit         sw;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_active = 0; m_run = 0; m_pos = 0; m_dir = 1; m_rem = 0;
            m_period = 1; m_mode = 0; m_start = 0; m_leds = '0;
            q.delete();
        end else begin
            cyc++;
            if (!m_active) begin
                m_pos = m_start;
                if (cfg_enable) begin
                    m_active = 1; m_run = 1; m_dir = 1; m_rem = m_period;
                    m_leds = 8'(1 << m_start);
                end
            end else if (m_run) begin
                if (m_rem == 1) begin
                    sw = 0;
                    if (m_mode == 2) begin
                        np = (m_pos + 1) % N;
                        sw = (m_pos == N - 1);
                        m_dir = 1;
                    end else begin
                        np = m_pos + m_dir;
                        if (np < 0 || np > N - 1) begin
                            m_dir = -m_dir;
                            np = m_pos + m_dir;
                            sw = 1;
                        end
                    end
                    m_leds = 8'(1 << np) | ((m_mode == 1) ? 8'(1 << m_pos) : 8'd0);
                    m_pos = np;
                    q.push_back('{cyc, np, m_leds, sw});
                    m_rem = m_period;
                end else if (cfg_enable) begin
                    m_rem--;
                end
                if (!cfg_enable) m_run = 0;
            end else if (cfg_enable) begin
                m_run = 1;
            end
            if (cfg_load) begin
                m_mode   = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
                m_period = (cfg_period == 0) ? 1 : int'(cfg_period);
                m_start  = (int'(cfg_start_pos) > N - 1) ? N - 1 : int'(cfg_start_pos);
            end
        end
    end

    exp_t e;
    always @(negedge ACLK) begin
        if (mon_en) begin
            chk("running", 32'(running), 32'(m_run));
            chk("pos", 32'(pos), 32'(m_pos));
            chk("dir", 32'(dir), 32'(m_dir > 0));
            chk("leds", 32'(leds), 32'(m_leds));
            if (step_pulse) begin
                if (q.size() == 0) begin
                    chk("unexpected_step", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("step_cycle", 32'(cyc), 32'(e.cyc));
                    chk("step_pos", 32'(pos), 32'(e.pos));
                    chk("step_leds", 32'(leds), 32'(e.leds));
                    chk("sweep_done", 32'(sweep_done), 32'(e.sw));
                end
            end else begin
                chk("missing_step", 32'(q.size()), 32'd0);
                q.delete();
                chk("sweep_no_step", 32'(sweep_done), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic load(input logic [1:0] m, input logic [31:0] p, input logic [2:0] s);
        cfg_mode = m; cfg_period = p; cfg_start_pos = s; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
    endtask

    task automatic wait_step();
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            if (step_pulse) return;
        end
        chk("wait_step_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        ARESETN = 1'b1; cfg_enable = 0; cfg_mode = 0; cfg_period = 0;
        cfg_start_pos = 0; cfg_load = 0; d6_start = 0; d6_load = 0;
        #2 ARESETN = 1'b0;
        mon_en = 1;
        tick(2);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_dir", 32'(dir), 32'd1);
        chk("rst_step", 32'(step_pulse), 32'd0);
        ARESETN = 1'b1;
        tick(2);

        load(2'b00, 32'd4, 3'd0); cfg_enable = 1; tick(80);
        load(2'b01, 32'd2, 3'd0); tick(40);
        load(2'b10, 32'd1, 3'd0); tick(24);
        load(2'b00, 32'd5, 3'd0); wait_step(); tick(2);
        cfg_enable = 0; tick(10);
        chk("hold_running", 32'(running), 32'd0);
        cfg_enable = 1; tick(20);
        load(2'b00, 32'd0, 3'd0); tick(10);
        load(2'b00, 32'd3, 3'd0); wait_step(); tick(1);
        load(2'b00, 32'd6, 3'd0); tick(30);

        repeat (400) begin
            int r;
            tick(1);
            r = int'($urandom_range(0, 99));
            if (r < 4) cfg_enable = ~cfg_enable;
            else if (r < 9) load(2'($urandom_range(0, 3)), 32'($urandom_range(0, 5)),
                                 3'($urandom_range(0, 7)));
        end
        cfg_enable = 1; load(2'b01, 32'd2, 3'd0); tick(7);

        @(posedge ACLK); #3 ARESETN = 1'b0;
        #1;
        chk("arst_leds", 32'(leds), 32'd0);
        chk("arst_pos", 32'(pos), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        cfg_enable = 0;
        @(negedge ACLK); ARESETN = 1'b1;
        tick(1);
        load(2'b00, 32'd2, 3'd5); tick(2);
        chk("idle_load_pos", 32'(pos), 32'd5);
        cfg_enable = 1; tick(30);

        d6_start = 3'd7; d6_load = 1; tick(1); d6_load = 0; tick(2);
        chk("clamp6_pos", 32'(d6_pos), 32'd5);
        d6_start = 3'd3; d6_load = 1; tick(1); d6_load = 0; tick(2);
        chk("start6_pos", 32'(d6_pos), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
